// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control block for a start/stop/clear stopwatch. Two raw, bouncy, active-low
// pushbuttons are synchronized and debounced into one-cycle press events. A
// three-state FSM (idle / run / paused) uses them to gate a prescaler. The
// prescaler produces an active-low one-cycle count enable for a downstream BCD
// counter chain, and a clear request for that chain.
//
// Parameters
//   CLK_DIV    clk cycles per count tick (>= 2)
//   DB_CYCLES  consecutive stable cycles needed to accept a button level (>= 1)
//
// Ports
//   clk          in   system clock, rising edge
//   ar           in   asynchronous reset, active low
//   btn_start_n  in   raw start/stop button, active low, asynchronous to clk
//   btn_clear_n  in   raw clear button, active low, asynchronous to clk
//   e_out        out  registered, active-low one-cycle count enable
//   ctr_clr      out  registered, active-high one-cycle counter clear
//   running      out  registered, high while in the run state
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned CLK_DIV   = 500000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic ar,
  input  logic btn_start_n,
  input  logic btn_clear_n,
  output logic e_out,
  output logic ctr_clr,
  output logic running
);

  localparam int unsigned PresW = $clog2(CLK_DIV);
  localparam int unsigned DbW   = $clog2(DB_CYCLES + 1);

  localparam logic [PresW-1:0] PresMax = PresW'(CLK_DIV - 1);
  localparam logic [DbW-1:0]   DbLast  = DbW'(DB_CYCLES - 1);

  // Button lane indices
  localparam int unsigned BtnStart = 0;
  localparam int unsigned BtnClear = 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer, debouncer, falling-edge detect
  // ---------------------------------------------------------------------------
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     db_level_q, db_level_d;
  logic [1:0]     db_prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];
  logic [1:0]     press;

  assign btn_raw = {btn_clear_n, btn_start_n};

  // The count tracks how many consecutive cycles the synchronized level has
  // disagreed with the accepted level; any agreement restarts it.
  always_comb begin
    db_level_d = db_level_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      db_level_q  <= 2'b11;
      db_prev_q   <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_level_q;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // Press = debounced 1->0; releases produce nothing
  assign press = db_prev_q & ~db_level_q;

  logic start_evt, clear_evt;
  assign start_evt = press[BtnStart];
  assign clear_evt = press[BtnClear];

  // ---------------------------------------------------------------------------
  // FSM, prescaler and registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic             e_out_q, e_out_d;
  logic             ctr_clr_q, ctr_clr_d;
  logic             running_q, running_d;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    ctr_clr_d = 1'b0;

    // The prescaler advances on every edge seen in run, including the edge
    // that leaves run, so a resume continues from where counting stopped.
    if (state_q == StRun) begin
      presc_d = (presc_q == PresMax) ? '0 : presc_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        presc_d = '0;
        // Clear wins over start outside of run
        if (clear_evt) begin
          ctr_clr_d = 1'b1;
        end else if (start_evt) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Clear is ignored while running
        if (start_evt) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (clear_evt) begin
          state_d   = StIdle;
          presc_d   = '0;
          ctr_clr_d = 1'b1;
        end else if (start_evt) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
        presc_d = '0;
      end
    endcase

    // Terminal count in run fires the enable even if this edge pauses
    e_out_d   = ~((state_q == StRun) && (presc_q == PresMax));
    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      e_out_q   <= 1'b1;
      ctr_clr_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      e_out_q   <= e_out_d;
      ctr_clr_q <= ctr_clr_d;
      running_q <= running_d;
    end
  end

  assign e_out   = e_out_q;
  assign ctr_clr = ctr_clr_q;
  assign running = running_q;

  // Enable only comes from run, clear only from idle/paused
  a_no_enable_and_clear : assert property (
    @(posedge clk) disable iff (!ar) !(!e_out_q && ctr_clr_q)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with CLK_DIV = 4, DB_CYCLES = 3. Inputs
// change on the falling edge; outputs are sampled on the falling edge. A
// button held low from a falling edge yields a press event that the FSM acts
// on at the sixth rising edge afterwards (2 sync + 3 debounce + 1 edge detect).
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic ar;
  logic btn_start_n;
  logic btn_clear_n;
  logic e_out;
  logic ctr_clr;
  logic running;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_DIV  (4),
    .DB_CYCLES(3)
  ) u_dut (
    .clk        (clk),
    .ar         (ar),
    .btn_start_n(btn_start_n),
    .btn_clear_n(btn_clear_n),
    .e_out      (e_out),
    .ctr_clr    (ctr_clr),
    .running    (running)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and check all three outputs
  task automatic step_chk(input logic exp_e, input logic exp_clr, input logic exp_run,
                          input string tag);
    @(negedge clk);
    check_eq({tag, ".e_out"}, {31'd0, e_out}, {31'd0, exp_e});
    check_eq({tag, ".ctr_clr"}, {31'd0, ctr_clr}, {31'd0, exp_clr});
    check_eq({tag, ".running"}, {31'd0, running}, {31'd0, exp_run});
  endtask

  task automatic idle_steps(input int n, input logic exp_run, input string tag);
    for (int i = 0; i < n; i++) step_chk(1'b1, 1'b0, exp_run, tag);
  endtask

  initial begin
    ar          = 1'b0;
    btn_start_n = 1'b1;
    btn_clear_n = 1'b1;

    // Reset values while held in reset
    @(negedge clk);
    @(negedge clk);
    check_eq("rst.e_out", {31'd0, e_out}, 32'd1);
    check_eq("rst.ctr_clr", {31'd0, ctr_clr}, 32'd0);
    check_eq("rst.running", {31'd0, running}, 32'd0);
    ar = 1'b1;

    // Quiet buttons: nothing happens
    idle_steps(20, 1'b0, "quiet");

    // Too-short press is rejected by the debouncer
    btn_start_n = 1'b0;
    idle_steps(2, 1'b0, "short");
    btn_start_n = 1'b1;
    idle_steps(8, 1'b0, "short_after");

    // Long press: run starts at the 6th edge, pulses every 4 from there
    btn_start_n = 1'b0;
    idle_steps(5, 1'b0, "start_db");
    step_chk(1'b1, 1'b0, 1'b1, "run_edge");
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) btn_start_n = 1'b1;
      step_chk((k % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("run_k%0d", k));
    end

    // Pause when the prescaler is 1 (event acts at k = 18)
    btn_start_n = 1'b0;
    for (int k = 13; k <= 17; k++) begin
      step_chk((k % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("pause_db_k%0d", k));
    end
    step_chk(1'b1, 1'b0, 1'b0, "pause_edge");
    btn_start_n = 1'b1;
    idle_steps(10, 1'b0, "paused_quiet");

    // Resume: prescaler kept at 2, so first pulse two edges later
    btn_start_n = 1'b0;
    idle_steps(5, 1'b0, "resume_db");
    step_chk(1'b1, 1'b0, 1'b1, "resume_edge");
    btn_start_n = 1'b1;
    step_chk(1'b1, 1'b0, 1'b1, "resume_1");
    step_chk(1'b0, 1'b0, 1'b1, "resume_pulse");

    // Clear while running is ignored
    btn_clear_n = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step_chk((j % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("clr_run_j%0d", j));
    end
    step_chk(1'b1, 1'b0, 1'b1, "clr_run_edge");
    btn_clear_n = 1'b1;
    for (int j = 7; j <= 12; j++) begin
      step_chk((j % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("clr_run_j%0d", j));
    end

    // Pause, then clear: one-cycle ctr_clr, back to idle
    btn_start_n = 1'b0;
    for (int j = 13; j <= 17; j++) begin
      step_chk((j % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("pause2_j%0d", j));
    end
    step_chk(1'b1, 1'b0, 1'b0, "pause2_edge");
    btn_start_n = 1'b1;
    idle_steps(6, 1'b0, "pause2_quiet");
    btn_clear_n = 1'b0;
    idle_steps(5, 1'b0, "clr_db");
    step_chk(1'b1, 1'b1, 1'b0, "clr_pulse");
    btn_clear_n = 1'b1;
    step_chk(1'b1, 1'b0, 1'b0, "clr_one_cycle");
    idle_steps(6, 1'b0, "clr_after");

    // Start, then pause exactly on terminal count: last pulse still fires
    btn_start_n = 1'b0;
    idle_steps(5, 1'b0, "run3_db");
    step_chk(1'b1, 1'b0, 1'b1, "run3_edge");
    btn_start_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step_chk((k % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("run3_k%0d", k));
    end
    btn_start_n = 1'b0;
    for (int k = 7; k <= 11; k++) begin
      step_chk((k % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("term_db_k%0d", k));
    end
    step_chk(1'b0, 1'b0, 1'b0, "term_pause_pulse");
    btn_start_n = 1'b1;
    idle_steps(8, 1'b0, "term_no_more");

    // Paused: start + clear together -> clear wins
    btn_start_n = 1'b0;
    btn_clear_n = 1'b0;
    idle_steps(5, 1'b0, "both_p_db");
    step_chk(1'b1, 1'b1, 1'b0, "both_p_edge");
    btn_start_n = 1'b1;
    btn_clear_n = 1'b1;
    idle_steps(7, 1'b0, "both_p_after");

    // Run: start + clear together -> start wins (pause, no clear)
    btn_start_n = 1'b0;
    idle_steps(5, 1'b0, "run4_db");
    step_chk(1'b1, 1'b0, 1'b1, "run4_edge");
    btn_start_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step_chk((k % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("run4_k%0d", k));
    end
    btn_start_n = 1'b0;
    btn_clear_n = 1'b0;
    for (int k = 7; k <= 11; k++) begin
      step_chk((k % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("both_r_k%0d", k));
    end
    step_chk(1'b0, 1'b0, 1'b0, "both_r_edge");
    btn_start_n = 1'b1;
    btn_clear_n = 1'b1;
    idle_steps(8, 1'b0, "both_r_after");

    // Resume (prescaler wrapped to 0), then reset while e_out is low
    btn_start_n = 1'b0;
    idle_steps(5, 1'b0, "run5_db");
    step_chk(1'b1, 1'b0, 1'b1, "run5_edge");
    btn_start_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step_chk((k % 4 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, $sformatf("run5_k%0d", k));
    end
    ar = 1'b0;
    #1;
    check_eq("async_rst.e_out", {31'd0, e_out}, 32'd1);
    check_eq("async_rst.ctr_clr", {31'd0, ctr_clr}, 32'd0);
    check_eq("async_rst.running", {31'd0, running}, 32'd0);
    @(negedge clk);
    ar = 1'b1;
    idle_steps(12, 1'b0, "post_rst");

    // Reset mid-debounce aborts the pending press
    btn_start_n = 1'b0;
    idle_steps(3, 1'b0, "db_abort");
    ar          = 1'b0;
    btn_start_n = 1'b1;
    @(negedge clk);
    ar = 1'b1;
    idle_steps(10, 1'b0, "db_abort_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 500000, meaning clk cycles per count tick (100 Hz at 50 MHz); legal range >= 2.
REQ-002 The block SHALL have parameter DB_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept a button level (20 ms at 50 MHz); legal range >= 1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all flops rising-edge.
REQ-005 The block SHALL have port ar, input, 1 bit: asynchronous reset, active-low.
REQ-006 The block SHALL have port btn_start_n, input, 1 bit: raw start/stop pushbutton, active-low, asynchronous to clk, bouncy.
REQ-007 The block SHALL have port btn_clear_n, input, 1 bit: raw clear pushbutton, active-low, asynchronous to clk, bouncy.
REQ-008 The block SHALL have port e_out, output, 1 bit: active-low one-cycle count enable that drives the downstream BCD counter chain's e_in.
REQ-009 The block SHALL have port ctr_clr, output, 1 bit: active-high one-cycle synchronous clear request for the counter chain.
REQ-010 The block SHALL have port running, output, 1 bit: high while in state RUN.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL feed a debouncer: debounced level updates only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any reversion restarts the count.
REQ-013 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; releases generate no event.
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSED.
REQ-015 On a start event, IDLE SHALL go to RUN and clear the prescaler to 0.
REQ-016 On a start event, RUN SHALL go to PAUSED.
REQ-017 On a start event, PAUSED SHALL go to RUN, keeping the prescaler value.
REQ-018 On a clear event, IDLE and PAUSED SHALL go to IDLE and pulse ctr_clr high for exactly one cycle, on the cycle after the event.
REQ-019 A clear event in RUN SHALL be ignored.
REQ-020 If start and clear events occur in the same cycle, start SHALL win in RUN (go to PAUSED, no ctr_clr); clear SHALL win in IDLE or PAUSED (go to IDLE, ctr_clr pulse, no run).
REQ-021 The prescaler SHALL count 0..CLK_DIV-1 and wrap only while state is RUN; it SHALL hold in PAUSED and stay 0 in IDLE.
REQ-022 e_out SHALL be registered and low for exactly one cycle, on the cycle after any edge where state is RUN and prescaler = CLK_DIV-1; otherwise it SHALL be high.
REQ-023 Consecutive e_out low pulses during uninterrupted RUN SHALL be exactly CLK_DIV cycles apart.
REQ-024 The first e_out pulse after IDLE->RUN SHALL occur CLK_DIV cycles after the transition edge.
REQ-025 A pause event coinciding with the terminal prescaler count SHALL still produce that e_out pulse; no pulse SHALL follow it.
REQ-026 e_out low and ctr_clr high SHALL never be asserted in the same cycle.
REQ-027 running SHALL be registered and equal to (state == RUN).

Reset
REQ-028 While ar = 0, the block SHALL immediately force state IDLE, prescaler 0, e_out = 1, ctr_clr = 0, running = 0.
REQ-029 While ar = 0, synchronizer and debounced levels SHALL reset to 1 (released) and debounce counters to 0, so no press event is generated at reset release.
REQ-030 Reset asserted mid-RUN or mid-debounce SHALL abort all activity with no further e_out or ctr_clr pulse until new events occur after release.

Verification (CLK_DIV = 4, DB_CYCLES = 3)
REQ-031 Reset, then hold both buttons high 20 cycles -> e_out = 1, ctr_clr = 0 and running = 0 throughout.
REQ-032 btn_start_n low for 2 cycles, then high -> no event, state stays IDLE; btn_start_n low for 10 cycles -> running rises, then e_out low 1 cycle every 4 cycles, first pulse 4 cycles after the RUN edge.
REQ-033 In RUN, press start at prescaler = 1 -> PAUSED, pulses stop; press start again -> first pulse 2 cycles after resume.
REQ-034 In RUN, press clear -> no ctr_clr and RUN continues; pause, then press clear -> ctr_clr high exactly 1 cycle, state IDLE.
REQ-035 In PAUSED, press start and clear in the same cycle -> IDLE with a ctr_clr pulse; in RUN, do the same -> PAUSED with no ctr_clr.
REQ-036 Assert ar low mid-RUN for 1 cycle -> outputs are immediately at reset values, and no e_out pulse occurs afterwards without a new start press.
